// File: rtl/pipeline_adder_arbiter_if.sv
// Requester and adder handshake bundle for pipeline_adder_arbiter; slave = arbiter side.
interface pipeline_adder_arbiter_if #(
   parameter int REQ_CNT        = 4,
   parameter int NUMBERS_AMOUNT = 8,
   parameter int NUMBER_WIDTH   = 4
);
   localparam int SUM_WIDTH = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT);

   logic [REQ_CNT*NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] req_data_i;
   logic [REQ_CNT-1:0]                             req_valid_i;
   logic [REQ_CNT-1:0]                             req_ready_o;
   logic [SUM_WIDTH-1:0]                           res_data_o;
   logic [REQ_CNT-1:0]                             res_valid_o;
   logic [REQ_CNT-1:0]                             res_ready_i;
   logic [NUMBERS_AMOUNT*NUMBER_WIDTH-1:0]         adder_data_o;
   logic                                           adder_valid_o;
   logic                                           adder_ready_i;
   logic [SUM_WIDTH-1:0]                           adder_sum_i;
   logic                                           adder_valid_i;
   logic                                           adder_ready_o;
   logic                                           err_o;

   modport slave (
      input  req_data_i, req_valid_i, res_ready_i, adder_ready_i, adder_sum_i, adder_valid_i,
      output req_ready_o, res_data_o, res_valid_o, adder_data_o, adder_valid_o, adder_ready_o, err_o
   );

   modport master (
      output req_data_i, req_valid_i, res_ready_i, adder_ready_i, adder_sum_i, adder_valid_i,
      input  req_ready_o, res_data_o, res_valid_o, adder_data_o, adder_valid_o, adder_ready_o, err_o
   );
endinterface

// File: rtl/pipeline_adder_arbiter.sv
// Round-robin sharing of one pipeline_adder; grant -> adder_valid_o next cycle, results routed combinationally.
// Backpressure: grants stall on a busy output stage or MAX_INFLIGHT tags outstanding; adder_ready_o follows the owner.
// Optional per-requester grant counters under PIPELINE_ADDER_ARB_STATS_EN.
module pipeline_adder_arbiter #(
   parameter int REQ_CNT        = 4,
   parameter int NUMBERS_AMOUNT = 8,
   parameter int NUMBER_WIDTH   = 4,
   parameter int MAX_INFLIGHT   = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   pipeline_adder_arbiter_if.slave  bus
`ifdef PIPELINE_ADDER_ARB_STATS_EN
   ,
   output logic [REQ_CNT*16-1:0]    stats_grant_cnt_o
`endif
);
   localparam int SUM_WIDTH = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT);
   localparam int VEC_W     = NUMBERS_AMOUNT * NUMBER_WIDTH;
   localparam int TAG_W     = $clog2(REQ_CNT);
   localparam int PTR_W     = $clog2(MAX_INFLIGHT);
   localparam int CNT_W     = PTR_W + 1;

   logic               adder_valid_q, adder_valid_d;
   logic [VEC_W-1:0]   adder_data_q, adder_data_d;
   logic [TAG_W-1:0]   last_grant_q, last_grant_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [TAG_W-1:0]   tag_mem_q [MAX_INFLIGHT];
   logic [TAG_W-1:0]   tag_mem_d [MAX_INFLIGHT];

   logic               fifo_empty;
   logic [TAG_W-1:0]   head_tag;
   logic               route_vld;
   logic               drop;
   logic               pop;
   logic               stage_free;
   logic               credit_ok;
   logic               grant_found;
   logic               grant;
   logic [TAG_W-1:0]   grant_idx;
   int                 cand;

   always_comb begin
      fifo_empty  = (cnt_q == '0);
      head_tag    = tag_mem_q[rd_ptr_q];
      route_vld   = !rst_i && bus.adder_valid_i && !fifo_empty;
      // A result with no outstanding tag has no owner: accept and discard it.
      drop        = !rst_i && bus.adder_valid_i && fifo_empty;
      pop         = route_vld && bus.res_ready_i[head_tag];
      stage_free  = !adder_valid_q || bus.adder_ready_i;
      credit_ok   = (cnt_q < CNT_W'(MAX_INFLIGHT)) || pop;

      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int i = 1; i <= REQ_CNT; i++) begin
         cand = int'(last_grant_q) + i;
         if (cand >= REQ_CNT) cand = cand - REQ_CNT;
         if (!grant_found && bus.req_valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = TAG_W'(cand);
         end
      end
      grant = !rst_i && stage_free && credit_ok && grant_found;

      bus.req_ready_o   = grant ? (REQ_CNT'(1) << grant_idx) : '0;
      bus.res_valid_o   = route_vld ? (REQ_CNT'(1) << head_tag) : '0;
      bus.res_data_o    = route_vld ? bus.adder_sum_i : '0;
      bus.adder_ready_o = pop || drop;
      bus.adder_valid_o = adder_valid_q;
      bus.adder_data_o  = adder_data_q;
      bus.err_o         = err_q;

      adder_valid_d = adder_valid_q;
      adder_data_d  = adder_data_q;
      if (grant) begin
         adder_valid_d = 1'b1;
         adder_data_d  = bus.req_data_i[int'(grant_idx)*VEC_W +: VEC_W];
      end else if (stage_free) begin
         adder_valid_d = 1'b0;
      end

      tag_mem_d = tag_mem_q;
      if (grant) tag_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d     = wr_ptr_q + PTR_W'(grant);
      rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
      last_grant_d = grant ? grant_idx : last_grant_q;
      err_d        = err_q || drop;

      // In-flight count tracks the tag FIFO occupancy, output stage included.
      cnt_d = cnt_q;
      if (grant && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!grant && pop) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         adder_valid_q <= 1'b0;
         adder_data_q  <= '0;
         last_grant_q  <= TAG_W'(REQ_CNT - 1);
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         adder_valid_q <= adder_valid_d;
         adder_data_q  <= adder_data_d;
         last_grant_q  <= last_grant_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
      end
   end

   // Tag storage needs no reset: entries are only read between matching pointers.
   always_ff @(posedge clk_i) begin
      tag_mem_q <= tag_mem_d;
   end

`ifdef PIPELINE_ADDER_ARB_STATS_EN
   logic [15:0] stats_q [REQ_CNT];
   logic [15:0] stats_d [REQ_CNT];

   always_comb begin
      for (int r = 0; r < REQ_CNT; r++) begin
         stats_d[r] = stats_q[r];
         if (grant && (int'(grant_idx) == r)) stats_d[r] = stats_q[r] + 16'd1;
         stats_grant_cnt_o[r*16 +: 16] = stats_q[r];
      end
   end

   always_ff @(posedge clk_i) begin
      for (int r = 0; r < REQ_CNT; r++) begin
         if (rst_i) stats_q[r] <= '0;
         else       stats_q[r] <= stats_d[r];
      end
   end
`endif
endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// Randomized bench for pipeline_adder_arbiter with a behavioural adder and a queue-based reference model.
module tb_pipeline_adder_arbiter;
   localparam int REQ  = 4;
   localparam int NA   = 8;
   localparam int NW   = 4;
   localparam int MAXF = 8;
   localparam int LAT  = 2;
   localparam int SW   = NW + $clog2(NA);
   localparam int VW   = NA * NW;

   typedef struct {
      logic [SW-1:0] sum;
      int            t;
   } pipe_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   pipeline_adder_arbiter_if #(.REQ_CNT(REQ), .NUMBERS_AMOUNT(NA), .NUMBER_WIDTH(NW)) bus ();

`ifdef PIPELINE_ADDER_ARB_STATS_EN
   logic [REQ*16-1:0] stats;
`endif

   pipeline_adder_arbiter #(
      .REQ_CNT(REQ), .NUMBERS_AMOUNT(NA), .NUMBER_WIDTH(NW), .MAX_INFLIGHT(MAXF)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
`ifdef PIPELINE_ADDER_ARB_STATS_EN
      ,
      .stats_grant_cnt_o (stats)
`endif
   );

   // stimulus knobs
   bit                rst;
   bit [REQ-1:0]      drv_vld, drv_res_rdy;
   logic [REQ*VW-1:0] drv_dat;
   bit                drv_add_rdy, spur;

   // reference model state
   bit                m_ov, m_err;
   logic [VW-1:0]     m_od;
   int                m_last;
   int                tagq[$];
   logic [SW-1:0]     ref_q[REQ][$];
   pipe_t             pipe[$];
   int                cyc;

   // bookkeeping
   int                n_chk, n_pass;
   int                n_grants, last_g, grant_cyc, rise_cyc, n_res;
   bit                prev_aov;
   logic [REQ-1:0]    res_owner;
   logic [SW-1:0]     res_sum;
   int                gcount[REQ];
   int                glog[$];

   function automatic logic [SW-1:0] vec_sum(input logic [VW-1:0] v);
      int s;
      s = 0;
      for (int i = 0; i < NA; i++) s += int'($signed(v[i*NW +: NW]));
      return SW'(s);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      int            g, tag;
      bit            grant, pop, drop, from_pipe, free, acc, exp_ar;
      logic [REQ-1:0] exp_rv, exp_rr;
      logic [SW-1:0] sum_in, exp_rd;
      logic [VW-1:0] aod;
      pipe_t         p;
      @(negedge clk_i);
      rst_i             = rst;
      bus.req_valid_i   = drv_vld;
      bus.req_data_i    = drv_dat;
      bus.res_ready_i   = drv_res_rdy;
      bus.adder_ready_i = drv_add_rdy;
      from_pipe = 1'b0;
      if (!rst && pipe.size() > 0 && pipe[0].t <= cyc) begin
         from_pipe         = 1'b1;
         bus.adder_valid_i = 1'b1;
         bus.adder_sum_i   = pipe[0].sum;
      end else if (!rst && spur) begin
         bus.adder_valid_i = 1'b1;
         bus.adder_sum_i   = SW'($urandom);
      end else begin
         bus.adder_valid_i = 1'b0;
         bus.adder_sum_i   = SW'($urandom);
      end
      sum_in = bus.adder_sum_i;
      #1;
      exp_rv = '0; exp_rd = '0; exp_ar = 1'b0; pop = 1'b0; drop = 1'b0; tag = 0;
      if (!rst && bus.adder_valid_i) begin
         if (tagq.size() > 0) begin
            tag    = tagq[0];
            exp_rv = REQ'(1) << tag;
            exp_rd = sum_in;
            pop    = drv_res_rdy[tag];
            exp_ar = pop;
         end else begin
            drop   = 1'b1;
            exp_ar = 1'b1;
         end
      end
      free  = !m_ov || drv_add_rdy;
      grant = 1'b0;
      g     = 0;
      if (!rst && free && (tagq.size() < MAXF || pop)) begin
         for (int i = 1; i <= REQ; i++) begin
            if (!grant && drv_vld[(m_last + i) % REQ]) begin
               grant = 1'b1;
               g     = (m_last + i) % REQ;
            end
         end
      end
      exp_rr = grant ? (REQ'(1) << g) : '0;
      chk("req_ready",   bus.req_ready_o,   exp_rr);
      chk("res_valid",   bus.res_valid_o,   exp_rv);
      chk("res_data",    bus.res_data_o,    exp_rd);
      chk("adder_ready", bus.adder_ready_o, exp_ar);
      chk("adder_valid", bus.adder_valid_o, m_ov);
      chk("adder_data",  bus.adder_data_o,  m_od);
      chk("err",         bus.err_o,         m_err);
      chk("res_onehot0", $onehot0(bus.res_valid_o), 1);
      if (pop) begin
         if (ref_q[tag].size() == 0) chk("ref_q_nonempty", 0, 1);
         else chk("ref_sum", bus.res_data_o, ref_q[tag].pop_front());
         n_res++;
         res_owner = bus.res_valid_o;
         res_sum   = bus.res_data_o;
      end
      if (bus.adder_valid_o && !prev_aov) rise_cyc = cyc;
      prev_aov = bus.adder_valid_o;
      aod = bus.adder_data_o;
      acc = m_ov && drv_add_rdy;
      @(posedge clk_i);
      if (rst) begin
         m_ov = 1'b0; m_od = '0; m_last = REQ - 1; m_err = 1'b0;
         tagq.delete();
         pipe.delete();
         for (int r = 0; r < REQ; r++) ref_q[r].delete();
      end else begin
         if (from_pipe && pop) void'(pipe.pop_front());
         if (acc) begin
            p.sum = vec_sum(aod);
            p.t   = cyc + LAT;
            pipe.push_back(p);
         end
         if (drop) m_err = 1'b1;
         if (pop) void'(tagq.pop_front());
         if (grant) begin
            m_ov = 1'b1;
            m_od = drv_dat[g*VW +: VW];
            tagq.push_back(g);
            ref_q[g].push_back(vec_sum(m_od));
            m_last    = g;
            last_g    = g;
            grant_cyc = cyc;
            n_grants++;
            gcount[g]++;
            glog.push_back(g);
         end else if (free) begin
            m_ov = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; drv_vld = '0; spur = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic rnd_dat();
      drv_dat = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic drain();
      int k;
      drv_vld = '0; drv_res_rdy = '1; drv_add_rdy = 1'b1;
      k = 0;
      while ((tagq.size() > 0 || m_ov) && k < 200) begin
         step();
         k++;
      end
      chk("drain_empty", tagq.size(), 0);
   endtask

   initial begin
      int ng0, nr0, k, mism;
      bus.req_valid_i = '0; bus.req_data_i = '0; bus.res_ready_i = '0;
      bus.adder_ready_i = 1'b0; bus.adder_valid_i = 1'b0; bus.adder_sum_i = '0;
      rst = 1'b1; drv_vld = '0; drv_res_rdy = '0; drv_dat = '0; drv_add_rdy = 1'b0; spur = 1'b0;
      m_ov = 1'b0; m_od = '0; m_last = REQ - 1; m_err = 1'b0; cyc = 0;
      n_chk = 0; n_pass = 0; n_grants = 0; n_res = 0; prev_aov = 1'b0;

      // reset state
      repeat (2) step();
      #1;
      chk("reset_adder_valid", bus.adder_valid_o, 0);
      chk("reset_adder_data",  bus.adder_data_o, 0);
      chk("reset_err",         bus.err_o, 0);
      chk("reset_req_ready",   bus.req_ready_o, 0);
      rst = 1'b0;

      // single requester, operands all 1
      do_reset();
      drv_dat = '0;
      drv_dat[2*VW-1:VW] = {NA{NW'(1)}};
      drv_vld = 4'b0010; drv_res_rdy = '1; drv_add_rdy = 1'b1;
      ng0 = n_grants; k = 0;
      while (n_grants == ng0 && k < 10) begin step(); k++; end
      drv_vld = '0;
      nr0 = n_res; k = 0;
      while (n_res == nr0 && k < 30) begin step(); k++; end
      chk("single_result_seen", n_res - nr0, 1);
      chk("single_owner",       res_owner, 4'b0010);
      chk("single_sum",         res_sum, 7'd8);
      chk("single_latency",     rise_cyc - grant_cyc, 1);
      #1;
      chk("single_err",         bus.err_o, 0);

      // fairness
      do_reset();
      glog.delete();
      for (int r = 0; r < REQ; r++) gcount[r] = 0;
      drv_vld = '1; drv_res_rdy = '1; drv_add_rdy = 1'b1;
      ng0 = n_grants; k = 0;
      while (n_grants - ng0 < 100 && k < 400) begin rnd_dat(); step(); k++; end
      chk("fair_grants", n_grants - ng0, 100);
      mism = 0;
      foreach (glog[i]) if (glog[i] != i % REQ) mism++;
      chk("fair_order", mism, 0);
      for (int r = 0; r < REQ; r++) chk("fair_count", gcount[r], 25);
      drain();

      // credit limit
      do_reset();
      drv_vld = '1; drv_res_rdy = '0; drv_add_rdy = 1'b1;
      ng0 = n_grants;
      repeat (30) begin rnd_dat(); step(); end
      chk("credit_grants", n_grants - ng0, 8);
      for (int w = 0; w < 4; w++) begin
         ng0 = n_grants;
         drv_res_rdy = '1;
         step();
         drv_res_rdy = '0;
         repeat (3) step();
         chk("credit_window", n_grants - ng0, 1);
      end
      drain();

      // random stress
      do_reset();
      ng0 = n_grants; k = 0;
      while (n_grants - ng0 < 200 && k < 5000) begin
         drv_vld = REQ'($urandom_range(15));
         rnd_dat();
         for (int r = 0; r < REQ; r++) drv_res_rdy[r] = 1'($urandom_range(1));
         drv_add_rdy = 1'($urandom_range(1));
         step();
         k++;
      end
      chk("stress_grants", n_grants - ng0, 200);
      drain();
      for (int r = 0; r < REQ; r++) chk("stress_refq_empty", ref_q[r].size(), 0);

      // reset with 5 vectors in flight
      do_reset();
      drv_vld = '1; drv_res_rdy = '0; drv_add_rdy = 1'b1;
      k = 0;
      while (tagq.size() < 5 && k < 50) begin rnd_dat(); step(); k++; end
      chk("midrst_inflight", tagq.size(), 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("midrst_adder_valid", bus.adder_valid_o, 0);
      chk("midrst_adder_data",  bus.adder_data_o, 0);
      drv_res_rdy = '1;
      ng0 = n_grants;
      step();
      chk("midrst_one_grant",   n_grants - ng0, 1);
      chk("midrst_first_grant", last_g, 0);
      drv_vld = '0;
      repeat (10) step();
      drain();

      // spurious result with empty tag FIFO
      do_reset();
      drv_vld = '0; drv_res_rdy = '1; drv_add_rdy = 1'b1;
      step();
      spur = 1'b1;
      step();
      spur = 1'b0;
      #1;
      chk("spur_err_set", bus.err_o, 1);
      repeat (5) step();
      #1;
      chk("spur_err_hold", bus.err_o, 1);
      do_reset();
      #1;
      chk("spur_err_clear", bus.err_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
